// File: rtl/vppm_period_estimator.sv
// Preamble period estimator for the VPPM receiver: times rising edges of VppmIn,
// averages 2**AVG_LOG2 mutually consistent periods and publishes (average - 2).
module vppm_period_estimator #(
  parameter int          MIN_PERIOD = 16,
  parameter logic [24:0] MAX_PERIOD = 25'h1FFFFFF,
  parameter int          AVG_LOG2   = 3,
  parameter int          TOL        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VppmIn,
  output logic        freqAvailable,
  output logic [31:0] signalFrequency,
  output logic        periodErr
);

  localparam int CNT_W  = 25;
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int WCNT_W = AVG_LOG2 + 1;

  localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [25:0]       TOL_D    = 26'(TOL);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  logic              vppmMeta_r;
  logic              vppmSync_r;
  logic              vppmPrev_r;
  logic              edge_r;
  logic [1:0]        state_r;
  logic [CNT_W-1:0]  periodCnt_r;
  logic [WCNT_W-1:0] winCnt_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  ref_r;
  logic              done_r;

  logic [1:0]        state_s;
  logic [CNT_W-1:0]  periodCnt_s;
  logic [WCNT_W-1:0] winCnt_s;
  logic [ACC_W-1:0]  acc_s;
  logic [CNT_W-1:0]  ref_s;
  logic              done_s;
  logic              err_s;
  logic              accept_s;
  logic              glitch_s;
  logic              timeout_s;
  logic              consistent_s;
  logic signed [25:0] diff_s;
  logic [25:0]       absDiff_s;
  logic [ACC_W-1:0]  avg_s;

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      vppmMeta_r <= 1'b0;
      vppmSync_r <= 1'b0;
      vppmPrev_r <= 1'b0;
      edge_r     <= 1'b0;
    end else begin
      vppmMeta_r <= VppmIn;
      vppmSync_r <= vppmMeta_r;
      vppmPrev_r <= vppmSync_r;
      edge_r     <= vppmSync_r & ~vppmPrev_r;
    end
  end

  assign glitch_s     = (periodCnt_r < MIN_P);
  assign accept_s     = edge_r && ((state_r == IDLE) || !glitch_s);
  assign diff_s       = $signed({1'b0, periodCnt_r}) - $signed({1'b0, ref_r});
  assign absDiff_s    = diff_s[25] ? 26'(-diff_s) : 26'(diff_s);
  assign consistent_s = (absDiff_s <= TOL_D);
  // An edge landing on the last legal count is a real period, so it beats the timeout.
  assign timeout_s    = (state_r != IDLE) && !accept_s &&
                        (periodCnt_r >= (MAX_PERIOD - 25'd1));
  assign avg_s        = acc_r >> AVG_LOG2;

  // Next-state logic for the period counter, averaging window and FSM.
  always_comb begin
    state_s     = state_r;
    periodCnt_s = periodCnt_r;
    winCnt_s    = winCnt_r;
    acc_s       = acc_r;
    ref_s       = ref_r;
    done_s      = 1'b0;
    err_s       = 1'b0;

    if (accept_s) begin
      periodCnt_s = 25'd1;
    end else if (periodCnt_r != MAX_PERIOD) begin
      periodCnt_s = periodCnt_r + 25'd1;
    end else begin
      periodCnt_s = periodCnt_r;
    end

    case (state_r)
      IDLE: begin
        if (edge_r) begin
          state_s  = MEASURE;
          winCnt_s = '0;
          acc_s    = '0;
        end else begin
          state_s = IDLE;
        end
      end
      MEASURE, LOCKED: begin
        if (done_r) begin
          state_s = LOCKED;
        end else if (accept_s) begin
          if (winCnt_r == '0) begin
            ref_s    = periodCnt_r;
            acc_s    = ACC_W'(periodCnt_r);
            winCnt_s = WCNT_W'(1);
          end else if (consistent_s) begin
            acc_s = acc_r + ACC_W'(periodCnt_r);
            if (winCnt_r == WIN_LAST) begin
              winCnt_s = '0;
              done_s   = 1'b1;
            end else begin
              winCnt_s = winCnt_r + WCNT_W'(1);
            end
          end else begin
            err_s    = 1'b1;
            ref_s    = periodCnt_r;
            acc_s    = ACC_W'(periodCnt_r);
            winCnt_s = WCNT_W'(1);
          end
        end else if (timeout_s) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      periodCnt_r <= '0;
      winCnt_r    <= '0;
      acc_r       <= '0;
      ref_r       <= '0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      periodCnt_r <= periodCnt_s;
      winCnt_r    <= winCnt_s;
      acc_r       <= acc_s;
      ref_r       <= ref_s;
      done_r      <= done_s;
    end
  end

  // Published estimate; the accumulator still holds the finished window sum while done_r is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      freqAvailable   <= 1'b0;
      signalFrequency <= 32'd0;
      periodErr       <= 1'b0;
    end else begin
      periodErr <= err_s;
      if (done_r) begin
        signalFrequency <= 32'(avg_s) - 32'd2;
        freqAvailable   <= 1'b1;
      end else if (timeout_s) begin
        signalFrequency <= signalFrequency;
        freqAvailable   <= 1'b0;
      end else begin
        signalFrequency <= signalFrequency;
        freqAvailable   <= freqAvailable;
      end
    end
  end

endmodule
